// File: rtl/cp0_unit.sv
// Coprocessor-0 responder: Status/Cause/EPC/Count/Compare with mfc0/mtc0, exception
// entry/return sequencing, exception target PC and a registered timer interrupt.
module cp0_unit #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0040_0004,
  parameter logic [31:0] STATUS_RESET = 32'h0000_0000,
  parameter bit          COUNT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mfc0,
  input  logic        mtc0,
  input  logic [31:0] pc,
  input  logic [4:0]  rd,
  input  logic [31:0] wdata,
  input  logic        exception,
  input  logic        eret,
  input  logic [4:0]  cause,
  output logic [31:0] rdata,
  output logic [31:0] status,
  output logic [31:0] exc_addr,
  output logic        timer_irq
);

  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [31:0] status_q,  status_d;
  logic [31:0] cause_q,   cause_d;
  logic [31:0] epc_q,     epc_d;
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_irq_q, timer_irq_d;
  logic        mtc0_win;

  // An mtc0 only takes effect when no exception or eret claims the same edge.
  assign mtc0_win = mtc0 && !exception && !eret;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    compare_d = compare_q;
    count_d   = COUNT_EN ? count_q + 32'd1 : count_q;

    if (exception) begin
      status_d     = {status_q[26:0], 5'b0};
      cause_d[6:2] = cause;
      epc_d        = pc;
    end else if (eret) begin
      status_d = {5'b0, status_q[31:5]};
    end else if (mtc0) begin
      unique case (rd)
        REG_COUNT:   count_d        = wdata;
        REG_COMPARE: compare_d      = wdata;
        REG_STATUS:  status_d       = wdata;
        REG_CAUSE:   cause_d[9:8]   = wdata[9:8];
        REG_EPC:     epc_d          = wdata;
        default:     ;
      endcase
    end

    if (count_d == compare_d) cause_d[15] = 1'b1;
    // A Compare write clears the timer flag and beats a simultaneous match.
    if (mtc0_win && rd == REG_COMPARE) cause_d[15] = 1'b0;

    timer_irq_d = cause_q[15] & status_q[15] & status_q[0];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_q    <= STATUS_RESET;
      cause_q     <= 32'h0;
      epc_q       <= 32'h0;
      count_q     <= 32'h0;
      compare_q   <= 32'hFFFF_FFFF;
      timer_irq_q <= 1'b0;
    end else begin
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (mfc0) begin
      unique case (rd)
        REG_COUNT:   rdata = count_q;
        REG_COMPARE: rdata = compare_q;
        REG_STATUS:  rdata = status_q;
        REG_CAUSE:   rdata = cause_q;
        REG_EPC:     rdata = epc_q;
        default:     rdata = 32'h0;
      endcase
    end
  end

  assign status    = status_q;
  assign exc_addr  = eret ? epc_q : EXC_VECTOR;
  assign timer_irq = timer_irq_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: the driver pushes expected outputs from a register-level
// model; a monitor pops and compares them on the falling edge of each cycle.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mfc0 = 1'b0, mtc0 = 1'b0, exception = 1'b0, eret = 1'b0;
  logic [31:0] pc = '0, wdata = '0;
  logic [4:0]  rd = '0, cause = '0;
  logic [31:0] rdata, status, exc_addr;
  logic        timer_irq;

  cp0_unit dut (
    .clk(clk), .reset(reset), .mfc0(mfc0), .mtc0(mtc0), .pc(pc), .rd(rd),
    .wdata(wdata), .exception(exception), .eret(eret), .cause(cause),
    .rdata(rdata), .status(status), .exc_addr(exc_addr), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] exc_addr;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference state: the five architectural registers and the delayed interrupt view.
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare;
  logic        m_irq;

  task automatic model_reset();
    m_status = 32'h0; m_cause = 32'h0; m_epc = 32'h0; m_count = 32'h0;
    m_compare = 32'hFFFF_FFFF; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] r);
    case (r)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, push expectation, advance model across the edge.
  task automatic step(input bit mf, input bit mt, input bit ex, input bit er,
                      input logic [4:0] r, input logic [31:0] wd,
                      input logic [31:0] p, input logic [4:0] c);
    exp_t        e;
    logic [31:0] n_status, n_cause, n_epc, n_count, n_compare;
    mfc0 = mf; mtc0 = mt; exception = ex; eret = er; rd = r; wdata = wd; pc = p; cause = c;

    e.rdata    = mf ? model_read(r) : 32'h0;
    e.status   = m_status;
    e.exc_addr = er ? m_epc : 32'h0040_0004;
    e.irq      = m_irq;
    sb_q.push_back(e);

    n_status = m_status; n_cause = m_cause; n_epc = m_epc;
    n_compare = m_compare; n_count = m_count + 1;
    if (ex) begin
      n_status = m_status << 5;
      n_cause[6:2] = c;
      n_epc = p;
    end else if (er) begin
      n_status = m_status >> 5;
    end else if (mt) begin
      case (r)
        5'd9:  n_count = wd;
        5'd11: n_compare = wd;
        5'd12: n_status = wd;
        5'd13: n_cause[9:8] = wd[9:8];
        5'd14: n_epc = wd;
        default: ;
      endcase
    end
    if (n_count == n_compare) n_cause[15] = 1'b1;
    if (mt && !ex && !er && r == 5'd11) n_cause[15] = 1'b0;

    @(posedge clk);
    #1;
    m_irq = m_cause[15] & m_status[15] & m_status[0];
    m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_count = n_count; m_compare = n_compare;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 5'd0);
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] wd);
    step(0, 1, 0, 0, r, wd, 32'h0, 5'd0);
  endtask

  task automatic rdreg(input logic [4:0] r);
    step(1, 0, 0, 0, r, 32'h0, 32'h0, 5'd0);
  endtask

  // Monitor: compares whatever expectation the driver queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rdata", rdata, e.rdata);
        check("status", status, e.status);
        check("exc_addr", exc_addr, e.exc_addr);
        check("timer_irq", {31'h0, timer_irq}, {31'h0, e.irq});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Read/write and unimplemented register.
    wr(5'd12, 32'h0000_FF01);
    rdreg(5'd12);
    rdreg(5'd5);
    wr(5'd5, 32'h1234_5678);
    rdreg(5'd5);

    // Mid-cycle reset after dirtying state; the following cycle is checked before its edge.
    wr(5'd14, 32'hCAFE_0000);
    reset = 1'b1; #1 reset = 1'b0;
    model_reset();
    rdreg(5'd14);
    rdreg(5'd12);

    // Exception entry and return.
    wr(5'd12, 32'h0000_0001);
    step(0, 0, 1, 0, 5'd0, 32'h0, 32'h0040_0100, 5'b01000);
    rdreg(5'd13);
    rdreg(5'd14);
    step(1, 0, 0, 1, 5'd12, 32'h0, 32'h0, 5'd0);
    rdreg(5'd12);

    // Priority: exception beats mtc0, exception beats eret, eret beats mtc0.
    step(0, 1, 1, 0, 5'd14, 32'hDEAD_BEEF, 32'h0040_0200, 5'd4);
    rdreg(5'd14);
    wr(5'd12, 32'h0000_0421);
    step(0, 0, 1, 1, 5'd0, 32'h0, 32'h0040_0300, 5'd9);
    step(0, 1, 0, 1, 5'd12, 32'hFFFF_FFFF, 32'h0, 5'd0);
    rdreg(5'd12);
    rdreg(5'd14);

    // Timer match, interrupt, and clear by Compare write.
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'd10);
    wr(5'd11, 32'd15);
    for (int i = 0; i < 6; i++) rdreg(5'd13);
    rdreg(5'd9);
    wr(5'd11, 32'd100);
    rdreg(5'd13);
    idle(2);
    // Match on the same edge as a Compare write: the clear wins.
    wr(5'd11, m_count + 32'd1);
    rdreg(5'd13);

    // Count wrap and Cause write mask.
    wr(5'd9, 32'hFFFF_FFFE);
    rdreg(5'd9);
    rdreg(5'd9);
    wr(5'd13, 32'hFFFF_FFFF);
    rdreg(5'd13);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [4:0]  r;
      logic [31:0] wd;
      int          k;
      bit          ex, er;
      k = int'($urandom_range(0, 5));
      case (k)
        0: r = 5'd9;  1: r = 5'd11; 2: r = 5'd12;
        3: r = 5'd13; 4: r = 5'd14; default: r = 5'($urandom);
      endcase
      wd = $urandom;
      if (r == 5'd11 && $urandom_range(0, 1) == 1) wd = m_count + 32'($urandom_range(1, 3));
      if (r == 5'd12 && $urandom_range(0, 1) == 1) wd = 32'h0000_8001;
      ex = ($urandom_range(0, 9) == 0);
      er = ($urandom_range(0, 9) == 0);
      step(1'($urandom), 1'($urandom), ex, er, r, wd, $urandom, 5'($urandom));
    end

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
